fp2smag_iter: RTL and testbench

Parametrised, multi-cycle converter from the team's floating-point format {sign, exponent[EW], fraction[FW]} to sign-magnitude integer [OW], with overflow and underflow flags. The value is 0.fraction × 2^exponent, and the fraction is normally normalised. It uses an iterative one-bit-per-cycle right shifter instead of a barrel shifter. A valid/ready handshake on both sides lets it sit between register-stage producers and consumers in the numeric datapath.

---
 rtl/fp2smag_pkg.sv | 29 ++
 rtl/fp_classify.sv | 29 ++
 rtl/fp2smag_iter.sv | 146 ++++++++++++++
 tb/tb_fp2smag_iter.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/fp2smag_pkg.sv
// rtl/fp2smag_pkg.sv - shared state encoding, width helpers and parameter legality check for fp2smag_iter
package fp2smag_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic int fp2smag_mw(input int ow);
        return ow - 1;
    endfunction

    function automatic int fp2smag_cw(input int fw);
        return $clog2(fw + 1);
    endfunction

    function automatic int fp2smag_in_w(input int ew, input int fw);
        return 1 + ew + fw;
    endfunction

    // The magnitude must fit inside the fraction and be reachable by the exponent range.
    function automatic bit fp2smag_legal(input int ew, input int fw, input int ow);
        int mw;
        mw = ow - 1;
        return (mw >= 1) && (mw <= fw) && (((1 << ew) - 1) >= mw);
    endfunction

endpackage

// File: rtl/fp_classify.sv
// rtl/fp_classify.sv - combinational exponent/fraction classifier: overflow, underflow, zero and shift count
module fp_classify
    import fp2smag_pkg::*;
#(
    parameter int EW = 4,
    parameter int FW = 8,
    parameter int MW = 7,
    parameter int CW = 4
) (
    input  logic [EW-1:0] exponent,
    input  logic [FW-1:0] fraction,
    output logic          of,
    output logic          uf,
    output logic          zero,
    output logic [CW-1:0] shift_n
);

    int exp_i;

    always_comb begin
        exp_i   = int'(exponent);
        of      = exp_i > MW;
        uf      = !of && (exponent == '0);
        zero    = (fraction == '0);
        // Normal exponents are at most MW <= FW, so the difference fits in CW bits.
        shift_n = (of || uf) ? '0 : CW'(FW - exp_i);
    end

endmodule

// File: rtl/fp2smag_iter.sv
// rtl/fp2smag_iter.sv - iterative float to sign-magnitude converter, one shift per cycle; FP2SMAG_ROUND_EN enables round half-up
module fp2smag_iter
    import fp2smag_pkg::*;
#(
    parameter int EW = 4,
    parameter int FW = 8,
    parameter int OW = 8
) (
    input  logic                             iClk,
    input  logic                             iReset,
    input  logic                             iValid,
    output logic                             oReady,
    input  logic [fp2smag_in_w(EW, FW)-1:0] iFp,
    output logic                             oValid,
    input  logic                             iReady,
    output logic [OW-1:0]                    oSmag,
    output logic                             oOF,
    output logic                             oUF
);

    localparam int MW = fp2smag_mw(OW);
    localparam int CW = fp2smag_cw(FW);

    if (!fp2smag_legal(EW, FW, OW)) begin : g_illegal
        $error("fp2smag_iter: illegal EW/FW/OW combination");
    end

    state_t        state_q, state_d;
    logic          sign_q, sign_d;
    logic [FW-1:0] frac_q, frac_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          of_q, of_d;
    logic          uf_q, uf_d;
`ifdef FP2SMAG_ROUND_EN
    logic          guard_q, guard_d;
`endif

    logic          cls_of, cls_uf, cls_zero;
    logic [CW-1:0] cls_n;

    fp_classify #(
        .EW(EW),
        .FW(FW),
        .MW(MW),
        .CW(CW)
    ) u_classify (
        .exponent(iFp[EW+FW-1:FW]),
        .fraction(iFp[FW-1:0]),
        .of      (cls_of),
        .uf      (cls_uf),
        .zero    (cls_zero),
        .shift_n (cls_n)
    );

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        frac_d  = frac_q;
        cnt_d   = cnt_q;
        of_d    = of_q;
        uf_d    = uf_q;
`ifdef FP2SMAG_ROUND_EN
        guard_d = guard_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (iValid) begin
                    sign_d  = iFp[EW+FW] & ~(cls_uf | (cls_zero & ~cls_of));
                    frac_d  = cls_uf ? '0 : iFp[FW-1:0];
                    cnt_d   = cls_n;
                    of_d    = cls_of;
                    uf_d    = cls_uf;
`ifdef FP2SMAG_ROUND_EN
                    guard_d = 1'b0;
`endif
                    state_d = (cls_n == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                frac_d  = frac_q >> 1;
`ifdef FP2SMAG_ROUND_EN
                guard_d = frac_q[0];
`endif
                cnt_d   = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (iReady) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            state_q <= ST_IDLE;
            sign_q  <= 1'b0;
            frac_q  <= '0;
            cnt_q   <= '0;
            of_q    <= 1'b0;
            uf_q    <= 1'b0;
`ifdef FP2SMAG_ROUND_EN
            guard_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            frac_q  <= frac_d;
            cnt_q   <= cnt_d;
            of_q    <= of_d;
            uf_q    <= uf_d;
`ifdef FP2SMAG_ROUND_EN
            guard_q <= guard_d;
`endif
        end
    end

    logic          hi_ovf;
    logic [MW:0]   sum;
    logic          res_of;
    logic [MW-1:0] res_mag;
    logic          res_sign;

    // Result is derived from registers that are frozen in DONE, so outputs hold under backpressure.
    always_comb begin
        hi_ovf   = (frac_q >> MW) != '0;
`ifdef FP2SMAG_ROUND_EN
        sum      = {1'b0, frac_q[MW-1:0]} + {{MW{1'b0}}, guard_q};
`else
        sum      = {1'b0, frac_q[MW-1:0]};
`endif
        res_of   = of_q | hi_ovf | sum[MW];
        res_mag  = res_of ? '1 : sum[MW-1:0];
        res_sign = sign_q & (res_mag != '0);
        oReady   = (state_q == ST_IDLE);
        oValid   = (state_q == ST_DONE);
        oSmag    = oValid ? {res_sign, res_mag} : '0;
        oOF      = oValid & res_of;
        oUF      = oValid & uf_q;
    end

endmodule

// File: tb/tb_fp2smag_iter.sv
// tb/tb_fp2smag_iter.sv - directed self-checking bench for fp2smag_iter (EW=4, FW=8, OW=8)
module tb_fp2smag_iter;

    logic        iClk = 1'b0;
    logic        iReset;
    logic        iValid;
    logic        oReady;
    logic [12:0] iFp;
    logic        oValid;
    logic        iReady;
    logic [7:0]  oSmag;
    logic        oOF;
    logic        oUF;

    int checks = 0;
    int passes = 0;

    fp2smag_iter #(.EW(4), .FW(8), .OW(8)) dut (
        .iClk  (iClk),
        .iReset(iReset),
        .iValid(iValid),
        .oReady(oReady),
        .iFp   (iFp),
        .oValid(oValid),
        .iReady(iReady),
        .oSmag (oSmag),
        .oOF   (oOF),
        .oUF   (oUF)
    );

    always #5 iClk = ~iClk;

`ifdef FP2SMAG_ROUND_EN
    localparam logic [7:0] E2_SMAG = 8'hFF;
    localparam logic       E2_OF   = 1'b1;
    localparam logic [7:0] E6_SMAG = 8'h1B;
    localparam logic [7:0] EH_SMAG = 8'h81;
`else
    localparam logic [7:0] E2_SMAG = 8'hFF;
    localparam logic       E2_OF   = 1'b0;
    localparam logic [7:0] E6_SMAG = 8'h1A;
    localparam logic [7:0] EH_SMAG = 8'h00;
`endif

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) passes++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic run_word(input string tag, input logic [12:0] fp, input logic [7:0] e_smag,
                            input logic e_of, input logic e_uf, input int e_lat);
        int lat;
        chk({tag, ".ready_in"}, 32'(oReady), 32'd1);
        iFp    = fp;
        iValid = 1'b1;
        tick();
        iValid = 1'b0;
        iFp    = '0;
        lat    = 1;
        while (!oValid && lat < 40) begin
            tick();
            lat++;
        end
        chk({tag, ".lat"}, 32'(lat), 32'(e_lat));
        chk({tag, ".smag"}, 32'(oSmag), 32'(e_smag));
        chk({tag, ".of"}, 32'(oOF), 32'(e_of));
        chk({tag, ".uf"}, 32'(oUF), 32'(e_uf));
        chk({tag, ".ready_busy"}, 32'(oReady), 32'd0);
        iReady = 1'b1;
        tick();
        iReady = 1'b0;
        chk({tag, ".valid_off"}, 32'(oValid), 32'd0);
        chk({tag, ".ready_back"}, 32'(oReady), 32'd1);
    endtask

    initial begin
        int lat;
        iReset = 1'b1;
        iValid = 1'b0;
        iReady = 1'b0;
        iFp    = '0;
        tick();
        tick();
        iReset = 1'b0;
        chk("rst.ready", 32'(oReady), 32'd1);
        chk("rst.valid", 32'(oValid), 32'd0);
        chk("rst.smag", 32'(oSmag), 32'd0);
        chk("rst.of", 32'(oOF), 32'd0);
        chk("rst.uf", 32'(oUF), 32'd0);

        run_word("v1_normal", 13'b0_0101_11010000, 8'h1A, 1'b0, 1'b0, 4);
        run_word("v2_full", 13'b1_0111_11111111, E2_SMAG, E2_OF, 1'b0, 2);
        run_word("v3_ovf", 13'b1_1000_10000000, 8'hFF, 1'b1, 1'b0, 1);
        run_word("v3_unf", 13'b1_0000_10000000, 8'h00, 1'b0, 1'b1, 1);
        run_word("v6_round", 13'b0_0101_11010100, E6_SMAG, 1'b0, 1'b0, 4);
        run_word("zero_frac", 13'b1_0011_00000000, 8'h00, 1'b0, 1'b0, 6);
        run_word("max_shift", 13'b1_0001_10000000, 8'h81, 1'b0, 1'b0, 8);
        run_word("half_lsb", 13'b1_0001_01000000, EH_SMAG, 1'b0, 1'b0, 8);

        // Backpressure: hold DONE with a new word waiting on the input.
        iFp    = 13'b0_0101_11010000;
        iValid = 1'b1;
        tick();
        iFp    = 13'b0_0101_11010100;
        lat    = 1;
        while (!oValid && lat < 40) begin
            tick();
            lat++;
        end
        chk("bp.lat", 32'(lat), 32'd4);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp.hold_valid", 32'(oValid), 32'd1);
            chk("bp.hold_smag", 32'(oSmag), 32'h1A);
            chk("bp.hold_ready", 32'(oReady), 32'd0);
        end
        iReady = 1'b1;
        tick();
        iReady = 1'b0;
        chk("bp.idle_valid", 32'(oValid), 32'd0);
        chk("bp.idle_ready", 32'(oReady), 32'd1);
        tick();
        iValid = 1'b0;
        chk("bp.second_busy", 32'(oReady), 32'd0);
        lat = 1;
        while (!oValid && lat < 40) begin
            tick();
            lat++;
        end
        chk("bp.second_lat", 32'(lat), 32'd4);
        chk("bp.second_smag", 32'(oSmag), 32'(E6_SMAG));
        iReady = 1'b1;
        tick();
        iReady = 1'b0;

        // Reset during the second SHIFT cycle of vector 1.
        iFp    = 13'b0_0101_11010000;
        iValid = 1'b1;
        tick();
        iValid = 1'b0;
        tick();
        iReset = 1'b1;
        tick();
        iReset = 1'b0;
        chk("mid_rst.valid", 32'(oValid), 32'd0);
        chk("mid_rst.ready", 32'(oReady), 32'd1);
        chk("mid_rst.smag", 32'(oSmag), 32'd0);
        chk("mid_rst.flags", 32'({oOF, oUF}), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("mid_rst.no_stale", 32'(oValid), 32'd0);
        end

        run_word("after_rst", 13'b1_0101_11010000, 8'h9A, 1'b0, 1'b0, 4);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
